// File: rtl/lcd_spi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lcd_spi_master
// Purpose  : SPI mode-0 master that streams framebuffer bytes from a
//            ready/valid source into the LCD board's SPI slave. Bytes are
//            shifted out MSB-first on mosi while miso is captured in
//            parallel. One start pulse delivers exactly FRAME_BYTES bytes,
//            after which frame_done pulses and the block returns to idle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   start      in   1   begin a frame (ignored while busy)
//   abort      in   1   synchronous cancel back to idle
//   tx_data    in   8   byte to send
//   tx_valid   in   1   tx_data is valid
//   tx_ready   out  1   byte accepted this cycle when tx_valid is high
//   sclk       out  1   SPI clock, idles low
//   mosi       out  1   SPI data out
//   miso       in   1   SPI data in
//   rx_data    out  8   byte captured from miso
//   rx_valid   out  1   one-cycle strobe, rx_data is new
//   busy       out  1   frame in progress
//   frame_done out  1   one-cycle strobe at end of frame
//   byte_cnt   out  14  bytes completed in current/last frame
// ============================================================================
module lcd_spi_master #(
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int FRAME_BYTES = 8001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        frame_done,
  output logic [13:0] byte_cnt
);

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [13:0] FRAME_LAST = 14'(FRAME_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  gap_q, gap_d;
  // Only the seven bits still to be sent are kept; bit 7 goes straight to
  // mosi when the byte is accepted.
  logic [6:0]  tx_sr_q, tx_sr_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [13:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    byte_cnt_d   = byte_cnt_q;

    if (abort) begin
      // Cancel overrides everything; byte_cnt keeps the completed count and
      // any partially shifted byte is simply dropped.
      state_d = ST_IDLE;
      sclk_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            byte_cnt_d = 14'd0;
            busy_d     = 1'b1;
            state_d    = ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (tx_valid) begin
            tx_sr_d = tx_data[6:0];
            mosi_d  = tx_data[7];
            div_d   = 8'd0;
            bit_d   = 3'd0;
            state_d = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_d  = 8'd0;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              // Rising edge: sample miso, MSB arrives first.
              rx_sr_d = {rx_sr_q[6:0], miso};
            end else if (bit_q != 3'd7) begin
              // Falling edge: present the next lower bit.
              mosi_d  = tx_sr_q[6];
              tx_sr_d = {tx_sr_q[5:0], 1'b0};
              bit_d   = bit_q + 3'd1;
            end else begin
              // Eighth falling edge: byte complete.
              rx_data_d  = rx_sr_q;
              rx_valid_d = 1'b1;
              byte_cnt_d = byte_cnt_q + 14'd1;
              gap_d      = 8'd0;
              state_d    = ST_GAP;
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end

        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (byte_cnt_q == FRAME_LAST) begin
              frame_done_d = 1'b1;
              busy_d       = 1'b0;
              state_d      = ST_IDLE;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_q        <= 8'd0;
      bit_q        <= 3'd0;
      gap_q        <= 8'd0;
      tx_sr_q      <= 7'd0;
      rx_sr_q      <= 8'd0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      byte_cnt_q   <= 14'd0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign tx_ready   = (state_q == ST_LOAD);
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign byte_cnt   = byte_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lcd_spi_master
// Purpose  : Directed self-checking bench for lcd_spi_master. Two instances:
//            dut_a (CLK_DIV=4, GAP=8, 3-byte frames) and dut_f (CLK_DIV=1,
//            GAP=1, 2-byte frames), both with miso looped back to mosi.
//            sel picks which instance the shared stimulus/observation uses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_master;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, tx_valid;
  logic [7:0] tx_data;
  bit   sel;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic start_a, abort_a, tx_valid_a, tx_ready_a, sclk_a, mosi_a, miso_a;
  logic rx_valid_a, busy_a, frame_done_a;
  logic [7:0] rx_data_a;
  logic [13:0] byte_cnt_a;
  logic start_f, abort_f, tx_valid_f, tx_ready_f, sclk_f, mosi_f, miso_f;
  logic rx_valid_f, busy_f, frame_done_f;
  logic [7:0] rx_data_f;
  logic [13:0] byte_cnt_f;

  assign start_a    = start & ~sel;
  assign abort_a    = abort & ~sel;
  assign tx_valid_a = tx_valid & ~sel;
  assign start_f    = start & sel;
  assign abort_f    = abort & sel;
  assign tx_valid_f = tx_valid & sel;
  assign miso_a     = mosi_a;
  assign miso_f     = mosi_f;

  logic s_tx_ready, s_sclk, s_mosi, s_rx_valid, s_busy, s_frame_done;
  logic [7:0] s_rx_data;
  logic [13:0] s_byte_cnt;
  assign s_tx_ready   = sel ? tx_ready_f   : tx_ready_a;
  assign s_sclk       = sel ? sclk_f       : sclk_a;
  assign s_mosi       = sel ? mosi_f       : mosi_a;
  assign s_rx_valid   = sel ? rx_valid_f   : rx_valid_a;
  assign s_busy       = sel ? busy_f       : busy_a;
  assign s_frame_done = sel ? frame_done_f : frame_done_a;
  assign s_rx_data    = sel ? rx_data_f    : rx_data_a;
  assign s_byte_cnt   = sel ? byte_cnt_f   : byte_cnt_a;

  lcd_spi_master #(.CLK_DIV(4), .GAP_CYCLES(8), .FRAME_BYTES(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .tx_data(tx_data), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
    .frame_done(frame_done_a), .byte_cnt(byte_cnt_a)
  );

  lcd_spi_master #(.CLK_DIV(1), .GAP_CYCLES(1), .FRAME_BYTES(2)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .abort(abort_f),
    .tx_data(tx_data), .tx_valid(tx_valid_f), .tx_ready(tx_ready_f),
    .sclk(sclk_f), .mosi(mosi_f), .miso(miso_f),
    .rx_data(rx_data_f), .rx_valid(rx_valid_f), .busy(busy_f),
    .frame_done(frame_done_f), .byte_cnt(byte_cnt_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Results of the most recent run_byte call; times are cycles after T0.
  bit ms_hs, ms_fd;
  int ms_nrise, ms_first, ms_last, ms_rvt, ms_nrv, ms_end, ms_t0;
  logic [7:0] ms_seq, ms_rxd;
  logic [13:0] ms_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte, then watch the selected DUT from the handshake edge
  // until tx_ready comes back or frame_done fires.
  task automatic run_byte(input logic [7:0] d, input bit hold, input int start_at);
    int t;
    int w;
    logic prev;
    ms_hs = 0; ms_fd = 0; ms_nrise = 0; ms_first = -1; ms_last = -1;
    ms_rvt = -1; ms_nrv = 0; ms_end = -1; ms_t0 = -1; ms_seq = 8'h00; ms_rxd = 8'h00;
    tx_data = d;
    tx_valid = 1'b1;
    w = 0;
    while (!s_tx_ready && w < 500) begin tick(); w++; end
    if (s_tx_ready) begin
      ms_hs = 1;
      tick();
      ms_t0 = cyc;
      if (!hold) tx_valid = 1'b0;
      t = 0;
      prev = s_sclk;
      while (ms_end < 0 && t < 300) begin
        tick();
        t++;
        start = (t == start_at);
        if (s_sclk && !prev) begin
          ms_nrise++;
          if (ms_first < 0) ms_first = t;
          ms_last = t;
          ms_seq = {ms_seq[6:0], s_mosi};
        end
        prev = s_sclk;
        if (s_rx_valid) begin
          ms_nrv++;
          if (ms_rvt < 0) begin ms_rvt = t; ms_rxd = s_rx_data; end
        end
        if (s_frame_done) begin ms_end = t; ms_fd = 1; end
        else if (s_tx_ready) ms_end = t;
      end
      start = 1'b0;
    end else begin
      tx_valid = 1'b0;
    end
    ms_cnt = s_byte_cnt;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if ({sclk_a, mosi_a, tx_ready_a, rx_valid_a, busy_a, frame_done_a, rx_data_a, byte_cnt_a} !== 28'd0) begin
      errors++; $display("FAIL reset_a: got %h expected 0", {sclk_a, mosi_a, tx_ready_a, rx_valid_a, busy_a, frame_done_a, rx_data_a, byte_cnt_a}); end
    checks++; if ({sclk_f, mosi_f, tx_ready_f, rx_valid_f, busy_f, frame_done_f, rx_data_f, byte_cnt_f} !== 28'd0) begin
      errors++; $display("FAIL reset_f: got %h expected 0", {sclk_f, mosi_f, tx_ready_f, rx_valid_f, busy_f, frame_done_f, rx_data_f, byte_cnt_f}); end
    @(negedge clk) rst = 1'b0;
    tick(); tick();
    checks++; if ({tx_ready_a, busy_a} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 00", {tx_ready_a, busy_a}); end
  endtask

  task automatic test_start_abort();
    sel = 0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    checks++; if ({s_busy, s_tx_ready} !== 2'b00) begin
      errors++; $display("FAIL start_abort_collision: got %b expected 00", {s_busy, s_tx_ready}); end
  endtask

  task automatic test_loopback();
    sel = 0;
    pulse_start();
    checks++; if ({s_tx_ready, s_busy, s_byte_cnt} !== {1'b1, 1'b1, 14'd0}) begin
      errors++; $display("FAIL start_latency: got %h expected %h", {s_tx_ready, s_busy, s_byte_cnt}, {1'b1, 1'b1, 14'd0}); end
    run_byte(8'hA5, 0, -1);
    checks++; if (!ms_hs || ms_nrise != 8) begin
      errors++; $display("FAIL lb_rises: got %0d (hs %0d) expected 8", ms_nrise, ms_hs); end
    checks++; if (ms_first != 4 || ms_last != 60) begin
      errors++; $display("FAIL lb_sclk_times: got %0d..%0d expected 4..60", ms_first, ms_last); end
    checks++; if (ms_seq !== 8'hA5) begin
      errors++; $display("FAIL lb_mosi_seq: got %h expected a5", ms_seq); end
    checks++; if (ms_rvt != 64 || ms_nrv != 1 || ms_rxd !== 8'hA5) begin
      errors++; $display("FAIL lb_rx: got t=%0d n=%0d data=%h expected t=64 n=1 data=a5", ms_rvt, ms_nrv, ms_rxd); end
    checks++; if (ms_end != 72 || ms_fd || ms_cnt !== 14'd1) begin
      errors++; $display("FAIL lb_ready_again: got t=%0d fd=%0d cnt=%0d expected t=72 fd=0 cnt=1", ms_end, ms_fd, ms_cnt); end
    run_byte(8'h12, 0, -1);
    run_byte(8'h34, 0, -1);
    checks++; if (ms_end != 72 || !ms_fd || ms_cnt !== 14'd3 || ms_rxd !== 8'h34) begin
      errors++; $display("FAIL lb_frame_done: got t=%0d fd=%0d cnt=%0d rx=%h expected t=72 fd=1 cnt=3 rx=34", ms_end, ms_fd, ms_cnt, ms_rxd); end
    tick();
    checks++; if ({s_busy, s_frame_done, s_byte_cnt} !== {1'b0, 1'b0, 14'd3}) begin
      errors++; $display("FAIL lb_after_frame: got %h expected %h", {s_busy, s_frame_done, s_byte_cnt}, {1'b0, 1'b0, 14'd3}); end
  endtask

  task automatic test_back_to_back();
    int t0p;
    int extra;
    sel = 0;
    pulse_start();
    run_byte(8'h00, 1, -1);
    t0p = ms_t0;
    checks++; if (ms_rxd !== 8'h00 || ms_nrv != 1) begin
      errors++; $display("FAIL b2b_byte0: got %h n=%0d expected 00 n=1", ms_rxd, ms_nrv); end
    run_byte(8'hFF, 1, -1);
    checks++; if (ms_t0 - t0p != 73 || ms_rxd !== 8'hFF || ms_nrv != 1) begin
      errors++; $display("FAIL b2b_byte1: got gap=%0d rx=%h expected gap=73 rx=ff", ms_t0 - t0p, ms_rxd); end
    t0p = ms_t0;
    run_byte(8'h3C, 1, -1);
    checks++; if (ms_t0 - t0p != 73 || ms_rxd !== 8'h3C || ms_nrv != 1) begin
      errors++; $display("FAIL b2b_byte2: got gap=%0d rx=%h expected gap=73 rx=3c", ms_t0 - t0p, ms_rxd); end
    checks++; if (!ms_fd || ms_end != 72 || ms_cnt !== 14'd3) begin
      errors++; $display("FAIL b2b_done: got fd=%0d t=%0d cnt=%0d expected fd=1 t=72 cnt=3", ms_fd, ms_end, ms_cnt); end
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (s_frame_done || s_rx_valid || s_tx_ready || s_busy || s_sclk) extra++;
    end
    tx_valid = 1'b0;
    checks++; if (extra != 0 || s_byte_cnt !== 14'd3) begin
      errors++; $display("FAIL b2b_quiet: got activity=%0d cnt=%0d expected 0 and 3", extra, s_byte_cnt); end
  endtask

  task automatic test_stall();
    int bad;
    sel = 0;
    pulse_start();
    run_byte(8'h11, 0, -1);
    checks++; if (ms_rxd !== 8'h11) begin
      errors++; $display("FAIL stall_byte0: got %h expected 11", ms_rxd); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (s_sclk || !s_tx_ready || s_byte_cnt !== 14'd1) bad++;
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
    run_byte(8'h22, 0, -1);
    checks++; if (ms_nrise != 8 || ms_first != 4 || ms_rvt != 64 || ms_rxd !== 8'h22 || ms_end != 72) begin
      errors++; $display("FAIL stall_byte1: got rises=%0d first=%0d rv=%0d rx=%h end=%0d expected 8 4 64 22 72", ms_nrise, ms_first, ms_rvt, ms_rxd, ms_end); end
    run_byte(8'h33, 0, -1);
    checks++; if (!ms_fd || ms_cnt !== 14'd3 || ms_rxd !== 8'h33) begin
      errors++; $display("FAIL stall_done: got fd=%0d cnt=%0d rx=%h expected 1 3 33", ms_fd, ms_cnt, ms_rxd); end
  endtask

  task automatic test_abort_restart();
    int w;
    int act;
    sel = 0;
    pulse_start();
    run_byte(8'h5A, 0, -1);
    tx_data = 8'hC3; tx_valid = 1'b1; w = 0;
    while (!s_tx_ready && w < 200) begin tick(); w++; end
    tick();
    tx_valid = 1'b0;
    repeat (20) tick();
    checks++; if (s_sclk !== 1'b1) begin
      errors++; $display("FAIL abort_third_rise: got sclk=%b expected 1", s_sclk); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({s_sclk, s_busy, s_tx_ready} !== 3'b000) begin
      errors++; $display("FAIL abort_next_edge: got %b expected 000", {s_sclk, s_busy, s_tx_ready}); end
    act = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (s_rx_valid || s_frame_done || s_sclk || s_busy) act++;
    end
    checks++; if (act != 0 || s_byte_cnt !== 14'd1) begin
      errors++; $display("FAIL abort_quiet: got activity=%0d cnt=%0d expected 0 and 1", act, s_byte_cnt); end
    pulse_start();
    checks++; if ({s_tx_ready, s_byte_cnt} !== {1'b1, 14'd0}) begin
      errors++; $display("FAIL restart_clear: got %h expected %h", {s_tx_ready, s_byte_cnt}, {1'b1, 14'd0}); end
    run_byte(8'hE7, 0, -1);
    checks++; if (ms_cnt !== 14'd1 || ms_rxd !== 8'hE7) begin
      errors++; $display("FAIL restart_byte0: got cnt=%0d rx=%h expected 1 e7", ms_cnt, ms_rxd); end
    run_byte(8'h01, 0, -1);
    run_byte(8'h80, 0, -1);
    checks++; if (!ms_fd || ms_cnt !== 14'd3 || ms_rxd !== 8'h80) begin
      errors++; $display("FAIL restart_done: got fd=%0d cnt=%0d rx=%h expected 1 3 80", ms_fd, ms_cnt, ms_rxd); end
  endtask

  task automatic test_reset_midbyte();
    int w;
    sel = 0;
    pulse_start();
    tx_data = 8'h96; tx_valid = 1'b1; w = 0;
    while (!s_tx_ready && w < 200) begin tick(); w++; end
    tick();
    tx_valid = 1'b0;
    repeat (5) tick();
    checks++; if (s_sclk !== 1'b1) begin
      errors++; $display("FAIL rst_pre_sclk: got %b expected 1", s_sclk); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({sclk_a, mosi_a, tx_ready_a, rx_valid_a, busy_a, frame_done_a, rx_data_a, byte_cnt_a} !== 28'd0) begin
      errors++; $display("FAIL rst_midbyte: got %h expected 0", {sclk_a, mosi_a, tx_ready_a, rx_valid_a, busy_a, frame_done_a, rx_data_a, byte_cnt_a}); end
    #1 rst = 1'b0;
    tick(); tick();
    pulse_start();
    run_byte(8'h69, 0, 10);
    checks++; if (ms_nrise != 8 || ms_first != 4 || ms_rvt != 64 || ms_rxd !== 8'h69) begin
      errors++; $display("FAIL busy_start_timing: got rises=%0d first=%0d rv=%0d rx=%h expected 8 4 64 69", ms_nrise, ms_first, ms_rvt, ms_rxd); end
    checks++; if (ms_end != 72 || ms_fd || ms_cnt !== 14'd1) begin
      errors++; $display("FAIL busy_start_count: got end=%0d fd=%0d cnt=%0d expected 72 0 1", ms_end, ms_fd, ms_cnt); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_fast();
    sel = 1;
    pulse_start();
    run_byte(8'h81, 0, -1);
    checks++; if (!ms_hs || ms_nrise != 8 || ms_first != 1 || ms_last != 15) begin
      errors++; $display("FAIL fast_sclk: got rises=%0d first=%0d last=%0d expected 8 1 15", ms_nrise, ms_first, ms_last); end
    checks++; if (ms_seq !== 8'h81 || ms_rvt != 16 || ms_rxd !== 8'h81) begin
      errors++; $display("FAIL fast_rx: got seq=%h rv=%0d rx=%h expected 81 16 81", ms_seq, ms_rvt, ms_rxd); end
    checks++; if (ms_end != 17 || ms_fd) begin
      errors++; $display("FAIL fast_ready: got t=%0d fd=%0d expected 17 0", ms_end, ms_fd); end
    run_byte(8'h42, 0, -1);
    checks++; if (!ms_fd || ms_end != 17 || ms_cnt !== 14'd2 || ms_rxd !== 8'h42) begin
      errors++; $display("FAIL fast_done: got fd=%0d t=%0d cnt=%0d rx=%h expected 1 17 2 42", ms_fd, ms_end, ms_cnt, ms_rxd); end
    tick();
    checks++; if (s_busy !== 1'b0) begin
      errors++; $display("FAIL fast_idle: got busy=%b expected 0", s_busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; sel = 0;
    test_reset();
    test_start_abort();
    test_loopback();
    test_back_to_back();
    test_stall();
    test_abort_restart();
    test_reset_midbyte();
    test_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
